// File: rtl/writeback_arbiter_if.sv
// Result/writeback bundle between the execution units and the writeback arbiter.
// Carries the ALU and load-unit valid/ready result handshakes plus the register-file write port.
// master: execution-unit/register-file side; slave: the arbiter itself.
interface writeback_arbiter_if;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;

  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;

  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  modport master (
    output alu_valid, alu_rd, alu_data,
    input  alu_ready,
    output lsu_valid, lsu_rd, lsu_data,
    input  lsu_ready,
    input  wb_en, wb_addr, wb_data
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    output alu_ready,
    input  lsu_valid, lsu_rd, lsu_data,
    output lsu_ready,
    output wb_en, wb_addr, wb_data
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Purpose: merges ALU results and queued load results onto one register-file write port, with bypass.
// Latency: selected result appears on wb_* one cycle later; a load result needs 2 cycles through an empty FIFO.
// Backpressure: lsu_ready drops when the FIFO is full; alu_ready drops on a same-rd conflict or a starved FIFO.
// Ports: clk/reset (sync, active-high), wb_if (ALU + LSU handshakes, write port),
//        q1/q2 bypass queries, fifo_count occupancy.
module writeback_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  writeback_arbiter_if.slave     wb_if,
  input  logic [4:0]             q1_addr,
  input  logic [4:0]             q2_addr,
  output logic                   q1_hit,
  output logic [31:0]            q1_data,
  output logic                   q2_hit,
  output logic [31:0]            q2_data,
  output logic [$clog2(DEPTH):0] fifo_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  // Load-result FIFO storage and state
  logic [4:0]    fifo_rd  [DEPTH];
  logic [31:0]   fifo_dat [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [SW-1:0] starve_cnt;

  // Output stage
  logic          wb_en_q;
  logic [4:0]    wb_addr_q;
  logic [31:0]   wb_data_q;

  logic          empty, full, force_pop, conflict;
  logic          alu_fire, push, pop, sel_vld;
  logic [4:0]    sel_rd;
  logic [31:0]   sel_dat;
  logic [PW-1:0] idx;
  logic          q1_fifo, q2_fifo;
  logic [31:0]   q1_fifo_dat, q2_fifo_dat;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign force_pop = !empty && (starve_cnt == SW'(STARVE_LIMIT));

  // Walk the live entries oldest to youngest; later matches overwrite earlier
  // ones so the bypass data ends up from the youngest matching entry.
  always_comb begin
    conflict    = 1'b0;
    q1_fifo     = 1'b0;
    q2_fifo     = 1'b0;
    q1_fifo_dat = '0;
    q2_fifo_dat = '0;
    idx         = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (CW'(i) < count) begin
        if (fifo_rd[idx] == wb_if.alu_rd) conflict = 1'b1;
        if (fifo_rd[idx] == q1_addr) begin
          q1_fifo     = 1'b1;
          q1_fifo_dat = fifo_dat[idx];
        end
        if (fifo_rd[idx] == q2_addr) begin
          q2_fifo     = 1'b1;
          q2_fifo_dat = fifo_dat[idx];
        end
      end
    end
  end

  // Holding the ALU back on a same-rd conflict keeps per-register ordering:
  // the queued load drains first because a stalled ALU never fires.
  assign wb_if.alu_ready = !reset && !force_pop && !conflict;
  // Readiness depends only on occupancy, so a same-cycle pop never frees a full FIFO.
  assign wb_if.lsu_ready = !reset && !full;

  assign alu_fire = wb_if.alu_valid && wb_if.alu_ready;
  assign pop      = !alu_fire && !empty;
  // rd = 0 loads are handshaken but never stored.
  assign push     = wb_if.lsu_valid && wb_if.lsu_ready && (wb_if.lsu_rd != 5'd0);
  assign sel_vld  = alu_fire || pop;
  assign sel_rd   = alu_fire ? wb_if.alu_rd   : fifo_rd[rd_ptr];
  assign sel_dat  = alu_fire ? wb_if.alu_data : fifo_dat[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]  <= wb_if.lsu_rd;
      fifo_dat[wr_ptr] <= wb_if.lsu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      wb_en_q    <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (empty || pop)
        starve_cnt <= '0;
      else if (starve_cnt != SW'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + SW'(1);
      wb_en_q <= sel_vld && (sel_rd != 5'd0);
      // Address/data only move on a real write; otherwise they hold.
      if (sel_vld && (sel_rd != 5'd0)) begin
        wb_addr_q <= sel_rd;
        wb_data_q <= sel_dat;
      end
    end
  end

  // Outputs are forced low while reset is held, including the cycle it is first seen.
  assign wb_if.wb_en   = !reset && wb_en_q;
  assign wb_if.wb_addr = reset ? 5'd0  : wb_addr_q;
  assign wb_if.wb_data = reset ? 32'd0 : wb_data_q;
  assign fifo_count    = reset ? '0    : count;

  assign q1_hit  = !reset && (q1_addr != 5'd0) &&
                   (q1_fifo || (wb_en_q && (wb_addr_q == q1_addr)));
  assign q2_hit  = !reset && (q2_addr != 5'd0) &&
                   (q2_fifo || (wb_en_q && (wb_addr_q == q2_addr)));
  assign q1_data = !q1_hit ? 32'd0 : (q1_fifo ? q1_fifo_dat : wb_data_q);
  assign q2_data = !q2_hit ? 32'd0 : (q2_fifo ? q2_fifo_dat : wb_data_q);
endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of load-unit result FIFO entries (power of two, 2..8).
REQ-002 Parameter STARVE_LIMIT, default 4, SHALL set the consecutive cycles a non-empty FIFO may be passed over before it is forced.
REQ-003 clk  input  1  SHALL be the clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-005 alu_valid / alu_ready  input / output  1 / 1  SHALL be the ALU result handshake.
REQ-006 alu_rd / alu_data  input  5 / 32  SHALL be the ALU destination register and result.
REQ-007 lsu_valid / lsu_ready  input / output  1 / 1  SHALL be the load-unit result handshake.
REQ-008 lsu_rd / lsu_data  input  5 / 32  SHALL be the load-unit destination register and result.
REQ-009 wb_en / wb_addr / wb_data  output  1 / 5 / 32  SHALL drive the register-file write port.
REQ-010 q1_addr, q2_addr  input  5  SHALL be the bypass query addresses.
REQ-011 q1_hit / q1_data, q2_hit / q2_data  output  1 / 32  SHALL be the bypass results.
REQ-012 fifo_count  output  clog2(DEPTH)+1  SHALL report the FIFO occupancy.

Function
REQ-013 A transfer SHALL occur on a port when valid and ready are both high at a rising edge.
REQ-014 lsu_ready SHALL be high iff fifo_count < DEPTH; a pop in the same cycle SHALL NOT allow a push when the FIFO is full.
REQ-015 An accepted LSU result SHALL be pushed at that edge and SHALL be poppable from the next cycle; if lsu_rd = 0 it SHALL be accepted and discarded.
REQ-016 force SHALL be high when the FIFO is non-empty and starve_cnt = STARVE_LIMIT.
REQ-017 conflict SHALL be high when alu_rd matches the rd of any valid FIFO entry.
REQ-018 alu_ready SHALL be !force && !conflict; it is combinational on alu_rd and the FIFO state.
REQ-019 Each cycle, if an ALU transfer occurs, the ALU result SHALL be selected; otherwise the FIFO head SHALL be popped and selected if the FIFO is non-empty.
REQ-020 The selected result SHALL appear registered on wb_en/wb_addr/wb_data in the next cycle, and wb_en SHALL be high exactly one cycle per selected result.
REQ-021 A selected result with rd = 0 SHALL produce wb_en = 0; when nothing is selected, wb_en SHALL be 0 and wb_addr/wb_data SHALL hold their previous values.
REQ-022 starve_cnt SHALL increment, saturating at STARVE_LIMIT, in each cycle the FIFO is non-empty and not popped, and SHALL clear on a pop or when the FIFO is empty.
REQ-023 FIFO order SHALL be preserved; results to the same rd SHALL reach wb in acceptance order, because ALU results never overtake queued LSU results to the same rd.
REQ-024 qN_hit SHALL be 1 when qN_addr != 0 and it matches a valid FIFO entry or the output stage (wb_en = 1).
REQ-025 qN_data SHALL come from the youngest matching FIFO entry; otherwise it SHALL come from the output stage.
REQ-026 qN_addr = 0 or no match SHALL give qN_hit = 0 and qN_data = 0.
REQ-027 Simultaneous push and pop when not full SHALL leave fifo_count unchanged, and pointers SHALL wrap modulo DEPTH.

Reset
REQ-028 While reset is high, alu_ready, lsu_ready, wb_en, q1_hit, q2_hit, q1_data, q2_data and fifo_count SHALL be 0, and wb_addr and wb_data SHALL be 0.
REQ-029 Reset SHALL empty the FIFO and clear starve_cnt; results in flight, including a pending output-stage write, SHALL be dropped.
REQ-030 The first transfer SHALL be possible in the first cycle after reset deasserts.

Verification
REQ-031 ALU alu_rd=5, alu_data=0x11, FIFO empty -> next cycle wb_en=1, wb_addr=5, wb_data=0x11, q1_addr=5 gives q1_hit=1 and q1_data=0x11.
REQ-032 LSU writes rd=7 with 0xA then 0xB, FIFO pops blocked by a stream of ALU rd=3 results -> q1_addr=7 gives q1_data=0xB; ALU alu_rd=7 sees alu_ready=0; wb_addr=7 is written with 0xA then 0xB.
REQ-033 FIFO holds one entry while ALU is valid every cycle -> after 4 cycles alu_ready=0 for one cycle, the FIFO pops, and starve_cnt returns to 0.
REQ-034 Push 4 LSU results with no pops -> fifo_count=4 and lsu_ready=0; a pop with lsu_valid=1 -> no push that cycle, and fifo_count=3 next cycle.
REQ-035 ALU alu_rd=0, alu_data=0xFF and LSU lsu_rd=0 transfers -> no wb_en pulse, fifo_count stays 0, and q1_addr=0 gives q1_hit=0.
REQ-036 reset asserted with fifo_count=3 and wb_en=1 -> next cycle all outputs are 0; after release, an LSU rd=2 result passes through the FIFO and reaches wb with a 2-cycle latency.
